// File: rtl/dds_sweep_controller_if.sv
// Sweep configuration channel (valid/ready) from the control-register block
// to dds_sweep_controller. The register block drives the master side.
interface dds_sweep_controller_if #(
  parameter int PHASE_WIDTH = 24,
  parameter int DWELL_WIDTH = 16
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [PHASE_WIDTH-1:0] cfg_start_fcw;
  logic [PHASE_WIDTH-1:0] cfg_stop_fcw;
  logic [PHASE_WIDTH-1:0] cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [PHASE_WIDTH-1:0] cfg_phase;
  logic                   cfg_continuous;

  modport master (
    output cfg_valid, cfg_start_fcw, cfg_stop_fcw, cfg_step, cfg_dwell,
           cfg_phase, cfg_continuous,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start_fcw, cfg_stop_fcw, cfg_step, cfg_dwell,
           cfg_phase, cfg_continuous,
    output cfg_ready
  );
endinterface

// File: rtl/dds_sweep_controller.sv
// DDS linear frequency sweep (chirp) sequencer.
// INIT settles for SETTLE_CYCLES, IDLE accepts configuration and start,
// RUN steps the FCW from start to stop with a per-step dwell.
// Optional macro DDS_SWEEP_PINGPONG_EN: triangle sweep (up then down) instead
// of sawtooth; when undefined the direction register and down path are absent.
module dds_sweep_controller #(
  parameter int PHASE_WIDTH   = 24,
  parameter int DWELL_WIDTH   = 16,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dds_sweep_controller_if.slave  cfg,
  input  logic                   start,
  input  logic                   abort,
  output logic                   dds_enable,
  output logic [PHASE_WIDTH-1:0] dds_fcw,
  output logic [PHASE_WIDTH-1:0] dds_phase_offset,
  output logic                   busy,
  output logic                   done,
  output logic                   wrap,
  output logic                   cfg_err
);
  localparam int PW = PHASE_WIDTH;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]          settle_cnt;
  logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [PW-1:0]          start_fcw, stop_fcw, step, phase;
  logic [DWELL_WIDTH-1:0] dwell;
  logic                   continuous, cfg_loaded;

  logic          en_nxt, busy_nxt, done_nxt, wrap_nxt, err_nxt, ready_nxt;
  logic [PW-1:0] fcw_nxt, phase_nxt;

  logic          handshake, cfg_ok, settle_done, tc, last_step, up_ok;
  logic [PW:0]   up_sum;

  assign handshake   = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok      = (cfg.cfg_start_fcw <= cfg.cfg_stop_fcw) && (cfg.cfg_step != '0);
  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign tc          = (dwell_cnt == dwell);
  // one extra bit so a step past the top of the FCW range cannot wrap to a small value
  assign up_sum      = {1'b0, dds_fcw} + {1'b0, step};
  assign up_ok       = (up_sum <= {1'b0, stop_fcw});

`ifdef DDS_SWEEP_PINGPONG_EN
  logic          dir, dir_nxt;   // 1 = descending
  logic [PW:0]   dn_diff;
  logic          dn_ok;
  assign dn_diff   = {1'b0, dds_fcw} - {1'b0, step};
  assign dn_ok     = !dn_diff[PW] && (dn_diff[PW-1:0] >= start_fcw);
  // a sweep that can neither go up nor down is a single point: treat it as the end
  assign last_step = dir ? !dn_ok : (!up_ok && !dn_ok);
`else
  assign last_step = !up_ok;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;

  // next-state logic; a config handshake shadows a simultaneous start
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (settle_done) state_nxt = S_IDLE;
      S_IDLE:  if (!handshake && start && cfg_loaded) state_nxt = S_RUN;
      S_RUN:   if (abort || (tc && last_step && !continuous)) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // next values of the registered outputs and the step datapath
  always_comb begin
    en_nxt        = dds_enable;
    busy_nxt      = busy;
    fcw_nxt       = dds_fcw;
    phase_nxt     = dds_phase_offset;
    dwell_cnt_nxt = dwell_cnt;
    done_nxt      = 1'b0;
    wrap_nxt      = 1'b0;
    err_nxt       = 1'b0;
    ready_nxt     = (state_nxt == S_IDLE);
`ifdef DDS_SWEEP_PINGPONG_EN
    dir_nxt       = dir;
`endif
    case (state)
      S_IDLE: begin
        err_nxt = handshake && !cfg_ok;
        if (state_nxt == S_RUN) begin
          en_nxt        = 1'b1;
          busy_nxt      = 1'b1;
          fcw_nxt       = start_fcw;
          phase_nxt     = phase;
          dwell_cnt_nxt = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
          dir_nxt       = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (state_nxt == S_IDLE) begin
          // abort or single-sweep end; abort suppresses done
          en_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          fcw_nxt   = '0;
          phase_nxt = '0;
          done_nxt  = !abort;
        end else if (tc) begin
          dwell_cnt_nxt = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
          if (!dir && up_ok)      fcw_nxt = up_sum[PW-1:0];
          else if (dir && dn_ok)  fcw_nxt = dn_diff[PW-1:0];
          else if (!dir && dn_ok) begin
            // top turn: skip repeating the top step
            fcw_nxt  = dn_diff[PW-1:0];
            dir_nxt  = 1'b1;
            wrap_nxt = continuous;
          end else begin
            // bottom turn (continuous only here): skip repeating start_fcw
            dir_nxt  = 1'b0;
            wrap_nxt = 1'b1;
            if (up_ok) fcw_nxt = up_sum[PW-1:0];
          end
`else
          if (up_ok) fcw_nxt = up_sum[PW-1:0];
          else begin
            fcw_nxt  = start_fcw;
            wrap_nxt = 1'b1;
          end
`endif
        end else begin
          dwell_cnt_nxt = dwell_cnt + DWELL_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // output and dwell registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dds_enable       <= 1'b0;
      dds_fcw          <= '0;
      dds_phase_offset <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      wrap             <= 1'b0;
      cfg_err          <= 1'b0;
      cfg.cfg_ready    <= 1'b0;
      dwell_cnt        <= '0;
`ifdef DDS_SWEEP_PINGPONG_EN
      dir              <= 1'b0;
`endif
    end else begin
      dds_enable       <= en_nxt;
      dds_fcw          <= fcw_nxt;
      dds_phase_offset <= phase_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      wrap             <= wrap_nxt;
      cfg_err          <= err_nxt;
      cfg.cfg_ready    <= ready_nxt;
      dwell_cnt        <= dwell_cnt_nxt;
`ifdef DDS_SWEEP_PINGPONG_EN
      dir              <= dir_nxt;
`endif
    end

  // post-reset settle counter, only advances in INIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)               settle_cnt <= '0;
    else if (state == S_INIT) settle_cnt <= settle_cnt + SW'(1);

  // configuration latch; rejected configurations leave the previous one intact
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_fcw  <= '0;
      stop_fcw   <= '0;
      step       <= '0;
      dwell      <= '0;
      phase      <= '0;
      continuous <= 1'b0;
      cfg_loaded <= 1'b0;
    end else if (handshake && cfg_ok) begin
      start_fcw  <= cfg.cfg_start_fcw;
      stop_fcw   <= cfg.cfg_stop_fcw;
      step       <= cfg.cfg_step;
      dwell      <= cfg.cfg_dwell;
      phase      <= cfg.cfg_phase;
      continuous <= cfg.cfg_continuous;
      cfg_loaded <= 1'b1;
    end
endmodule
